npu_df_seq: RTL and testbench
=============================

# npu_df_seq

Parametrised tiled-loop dataflow sequencer for the SEU NPU, replacing the fixed output-reuse loop in the master control unit. It takes one layer's tile counts and a reuse mode, then walks the Nt/IYt/Mt tile nest. For each tile it issues fetch-IFM, fetch-weight, compute and transmit-OFM requests to MemCtrl and the calculating unit. It supports output-reuse (OR) and weight-reuse (WR) loop orders, and reports layer completion back to the master FSM.

## Interface
- NT_W, 8, width of Nt tile count/counter
- MT_W, 12, width of Mt tile count/counter
- YT_W, 11, width of IYt tile count/counter
- clk_trans  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches config and begins a layer
- mode  in  1  0 = OR, 1 = WR (latched at start)
- Nt_times  in  NT_W  output-channel tiles (≥1)
- Mt_times  in  MT_W  input-channel tiles (≥1)
- IYt_times  in  YT_W  row tiles (≥1)
- ft_ifm_req / ft_wt_req / cal_req / tx_ofm_req  out  1  level requests
- ft_ifm_done / ft_wt_done / cal_done / tx_ofm_done  in  1  one-cycle completion pulses
- n_cnt / m_cnt / y_cnt  out  NT_W / MT_W / YT_W  current tile indices
- first_acc  out  1  m_cnt == 0 while cal_req
- last_acc  out  1  m_cnt == Mt_times−1 while cal_req
- busy  out  1  state ≠ IDLE
- layer_done  out  1  one-cycle pulse at end of layer
- cfg_err  out  1  one-cycle pulse when start arrives with any *_times == 0

## Operation
- States: IDLE, FT_IFM, FT_WT, CAL, TX_OFM, DONE (one-hot; one-hot vector must never hold zero or two bits).
- Each request output is high exactly while in its state. Its done input is sampled only in that state; done outside its state is ignored.
- IDLE: start with valid config → latch config, clear counters. OR goes to FT_IFM; WR goes to FT_WT. A zero count → cfg_err, stay IDLE. start outside IDLE is ignored.
- OR loop nest (outer→inner): n, y, m.
  - FT_IFM → FT_WT → CAL for every m.
  - CAL on cal_done: if m ≠ last, m++ and go to FT_IFM. Else go to TX_OFM.
  - TX_OFM on tx_ofm_done: m = 0, advance y (wrap to 0, then n++). Go to FT_IFM, or to DONE if n and y were both last.
- WR loop nest: n, m, y.
  - FT_WT only when y == 0; then FT_IFM → CAL for every y.
  - CAL on cal_done: if m == last, go to TX_OFM. Else advance y; on y wrap, m++ and go to FT_WT, otherwise go to FT_IFM.
  - TX_OFM on tx_ofm_done: advance y, wrapping to 0 with m++ → FT_WT.
    - At m and y last: m = 0, n++ → FT_WT.
    - At n, m and y all last → DONE.
  - The PE holds partial sums for all y rows between m passes.
- DONE: layer_done for one cycle, then IDLE.
- Counters: compare against latched times−1 in the counter's own width. Wrap to 0, never exceed times−1. Counters are held outside the transitions above.

## Timing
- Reset (synchronous): state IDLE; all counters 0; every output 0.
- rst asserted mid-layer aborts on the next edge with the same values. Outstanding done pulses afterwards are ignored.
- Latency from start to first request (ft_ifm_req in OR, ft_wt_req in WR): 1 cycle.
- done pulse at edge k → request deasserts and the next request asserts at edge k+1 (one registered transition, no gap cycle).
- layer_done is asserted the cycle after the final tx_ofm_done; busy falls one cycle later.
- start in the same cycle as layer_done is ignored (state is DONE, not IDLE).
- Counter updates and the state transition occur on the same edge; counters are valid while each request is high.

## Structure
- Shared package npu_df_pkg holds:
  - state encoding localparams (S_IDLE..S_DONE bit indices)
  - mode constants MODE_OR = 0, MODE_WR = 1
  - default widths
- One natural sub-module: npu_tile_cnt.
  - Parametrised width; ports inc, clr, limit.
  - Outputs cnt and is_last.
  - Instantiated three times for n, m, y.

## Test plan
- OR with Nt=1, Mt=1, IYt=1, zero-latency dones → request order ifm, wt, cal, tx. layer_done exactly 5 cycles after start; first_acc and last_acc both high during cal.
- OR with Nt=2, Mt=3, IYt=2 → 12 ifm, 12 wt, 12 cal, 4 tx. tx issued with (n,y) = (0,0), (0,1), (1,0), (1,1); m_cnt resets after each tx.
- WR with Nt=2, Mt=3, IYt=2 → 6 wt, 12 ifm, 12 cal, 4 tx. tx only while m_cnt == 2; each wt request shows y_cnt == 0.
- start with Mt_times=0 → cfg_err pulse, busy stays 0, no requests. A following valid start runs normally.
- rst asserted during CAL of the OR 2/3/2 run, then a late cal_done → all outputs 0, state IDLE, no response to the done.
- Spurious ft_wt_done while in FT_IFM, and start while busy → both ignored; the request and counter sequence is identical to the clean run.

Source files
------------

// File: rtl/npu_df_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_df_pkg
// Description : Shared constants for the NPU tiled-loop dataflow sequencer.
//               Holds the one-hot state bit indices and state vectors, the
//               reuse-mode encoding and the default tile-counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_df_pkg;

    // Default tile-counter widths
    localparam int unsigned NT_W_DEF = 8;
    localparam int unsigned MT_W_DEF = 12;
    localparam int unsigned YT_W_DEF = 11;

    // One-hot state bit indices
    localparam int unsigned S_IDLE   = 0;
    localparam int unsigned S_FT_IFM = 1;
    localparam int unsigned S_FT_WT  = 2;
    localparam int unsigned S_CAL    = 3;
    localparam int unsigned S_TX_OFM = 4;
    localparam int unsigned S_DONE   = 5;
    localparam int unsigned NUM_ST   = 6;

    // One-hot state vectors
    localparam logic [NUM_ST-1:0] ST_IDLE   = 6'b000001;
    localparam logic [NUM_ST-1:0] ST_FT_IFM = 6'b000010;
    localparam logic [NUM_ST-1:0] ST_FT_WT  = 6'b000100;
    localparam logic [NUM_ST-1:0] ST_CAL    = 6'b001000;
    localparam logic [NUM_ST-1:0] ST_TX_OFM = 6'b010000;
    localparam logic [NUM_ST-1:0] ST_DONE   = 6'b100000;

    // Loop-order (reuse) modes
    localparam logic MODE_OR = 1'b0;
    localparam logic MODE_WR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/npu_tile_cnt.sv
`default_nettype none
// ============================================================================
// Module      : npu_tile_cnt
// Description : Wrapping tile index counter. Counts 0..limit, returning to 0
//               after limit. Clear has priority over increment. is_last
//               flags the final index of the loop.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_tile_cnt
    import npu_df_pkg::*;
#(
    parameter int unsigned W = NT_W_DEF
) (
    input  logic         clk_trans,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         is_last
);

    logic [W-1:0] r_cnt;

    // Index register: clear, or step with wrap at the latched limit
    always_ff @(posedge clk_trans) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            if (r_cnt == limit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

    assign cnt     = r_cnt;
    assign is_last = (r_cnt == limit);

endmodule
`default_nettype wire

// File: rtl/npu_df_seq.sv
`default_nettype none
// ============================================================================
// Module      : npu_df_seq
// Description : Tiled-loop dataflow sequencer. Walks the Nt / IYt / Mt tile
//               nest of one layer and issues fetch-IFM, fetch-weight,
//               compute and transmit-OFM requests. Supports output-reuse
//               (n, y, m) and weight-reuse (n, m, y) loop orders.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_df_seq
    import npu_df_pkg::*;
#(
    parameter int unsigned NT_W = NT_W_DEF,
    parameter int unsigned MT_W = MT_W_DEF,
    parameter int unsigned YT_W = YT_W_DEF
) (
    input  logic            clk_trans,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic [NT_W-1:0] Nt_times,
    input  logic [MT_W-1:0] Mt_times,
    input  logic [YT_W-1:0] IYt_times,
    output logic            ft_ifm_req,
    output logic            ft_wt_req,
    output logic            cal_req,
    output logic            tx_ofm_req,
    input  logic            ft_ifm_done,
    input  logic            ft_wt_done,
    input  logic            cal_done,
    input  logic            tx_ofm_done,
    output logic [NT_W-1:0] n_cnt,
    output logic [MT_W-1:0] m_cnt,
    output logic [YT_W-1:0] y_cnt,
    output logic            first_acc,
    output logic            last_acc,
    output logic            busy,
    output logic            layer_done,
    output logic            cfg_err
);

    logic [NUM_ST-1:0] r_state;
    logic [NUM_ST-1:0] w_state_nxt;

    logic              r_mode;
    logic [NT_W-1:0]   r_nt_lim;
    logic [MT_W-1:0]   r_mt_lim;
    logic [YT_W-1:0]   r_yt_lim;
    logic              r_cfg_err;

    logic              w_cfg_zero;
    logic              w_latch;
    logic              w_cnt_clr;
    logic              w_m_clr;
    logic              w_n_inc;
    logic              w_m_inc;
    logic              w_y_inc;
    logic              w_cfg_err_nxt;
    logic              w_n_last;
    logic              w_m_last;
    logic              w_y_last;

    assign w_cfg_zero = (Nt_times == '0) | (Mt_times == '0) | (IYt_times == '0);

    // State register
    always_ff @(posedge clk_trans) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Layer configuration latch and config-error pulse
    always_ff @(posedge clk_trans) begin
        if (rst) begin
            r_mode    <= MODE_OR;
            r_nt_lim  <= '0;
            r_mt_lim  <= '0;
            r_yt_lim  <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_err_nxt;
            if (w_latch) begin
                r_mode   <= mode;
                r_nt_lim <= Nt_times - NT_W'(1);
                r_mt_lim <= Mt_times - MT_W'(1);
                r_yt_lim <= IYt_times - YT_W'(1);
            end
        end
    end

    // Next state and loop-counter control for both loop orders
    always_comb begin
        w_state_nxt   = r_state;
        w_latch       = 1'b0;
        w_cnt_clr     = 1'b0;
        w_m_clr       = 1'b0;
        w_n_inc       = 1'b0;
        w_m_inc       = 1'b0;
        w_y_inc       = 1'b0;
        w_cfg_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_cfg_zero) begin
                        w_cfg_err_nxt = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = (mode == MODE_WR) ? ST_FT_WT : ST_FT_IFM;
                    end
                end
            end
            ST_FT_IFM: begin
                if (ft_ifm_done) begin
                    w_state_nxt = (r_mode == MODE_WR) ? ST_CAL : ST_FT_WT;
                end
            end
            ST_FT_WT: begin
                if (ft_wt_done) begin
                    w_state_nxt = (r_mode == MODE_WR) ? ST_FT_IFM : ST_CAL;
                end
            end
            ST_CAL: begin
                if (cal_done) begin
                    if (w_m_last) begin
                        w_state_nxt = ST_TX_OFM;
                    end else if (r_mode == MODE_OR) begin
                        w_m_inc     = 1'b1;
                        w_state_nxt = ST_FT_IFM;
                    end else begin
                        // WR: sweep all rows with the same weights, then
                        // move to the next input-channel tile
                        w_y_inc = 1'b1;
                        if (w_y_last) begin
                            w_m_inc     = 1'b1;
                            w_state_nxt = ST_FT_WT;
                        end else begin
                            w_state_nxt = ST_FT_IFM;
                        end
                    end
                end
            end
            ST_TX_OFM: begin
                if (tx_ofm_done) begin
                    w_y_inc = 1'b1;
                    if (r_mode == MODE_OR) begin
                        w_m_clr     = 1'b1;
                        w_n_inc     = w_y_last;
                        w_state_nxt = (w_n_last && w_y_last) ? ST_DONE : ST_FT_IFM;
                    end else if (w_y_last) begin
                        // WR: every row of this output tile drained
                        w_m_clr     = 1'b1;
                        w_n_inc     = 1'b1;
                        w_state_nxt = w_n_last ? ST_DONE : ST_FT_WT;
                    end else begin
                        w_state_nxt = ST_FT_IFM;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request and status outputs decoded from the one-hot state
    always_comb begin
        ft_ifm_req = r_state[S_FT_IFM];
        ft_wt_req  = r_state[S_FT_WT];
        cal_req    = r_state[S_CAL];
        tx_ofm_req = r_state[S_TX_OFM];
        layer_done = r_state[S_DONE];
        busy       = ~r_state[S_IDLE];
        first_acc  = r_state[S_CAL] & (m_cnt == '0);
        last_acc   = r_state[S_CAL] & w_m_last;
        cfg_err    = r_cfg_err;
    end

    npu_tile_cnt #(
        .W (NT_W)
    ) u_n_cnt (
        .clk_trans (clk_trans),
        .rst       (rst),
        .clr       (w_cnt_clr),
        .inc       (w_n_inc),
        .limit     (r_nt_lim),
        .cnt       (n_cnt),
        .is_last   (w_n_last)
    );

    npu_tile_cnt #(
        .W (MT_W)
    ) u_m_cnt (
        .clk_trans (clk_trans),
        .rst       (rst),
        .clr       (w_cnt_clr | w_m_clr),
        .inc       (w_m_inc),
        .limit     (r_mt_lim),
        .cnt       (m_cnt),
        .is_last   (w_m_last)
    );

    npu_tile_cnt #(
        .W (YT_W)
    ) u_y_cnt (
        .clk_trans (clk_trans),
        .rst       (rst),
        .clr       (w_cnt_clr),
        .inc       (w_y_inc),
        .limit     (r_yt_lim),
        .cnt       (y_cnt),
        .is_last   (w_y_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_npu_df_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_npu_df_seq
// Description : Self-checking bench for npu_df_seq. A table of layer
//               configurations is run; each request rising edge is compared
//               against a scoreboard built from the loop-nest model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_df_seq;

    localparam int NT_W = 8;
    localparam int MT_W = 12;
    localparam int YT_W = 11;

    logic            clk_trans = 1'b0;
    logic            rst       = 1'b1;
    logic            start     = 1'b0;
    logic            mode      = 1'b0;
    logic [NT_W-1:0] Nt_times  = '0;
    logic [MT_W-1:0] Mt_times  = '0;
    logic [YT_W-1:0] IYt_times = '0;
    logic            ft_ifm_done = 1'b0;
    logic            ft_wt_done  = 1'b0;
    logic            cal_done    = 1'b0;
    logic            tx_ofm_done = 1'b0;
    logic            ft_ifm_req, ft_wt_req, cal_req, tx_ofm_req;
    logic [NT_W-1:0] n_cnt;
    logic [MT_W-1:0] m_cnt;
    logic [YT_W-1:0] y_cnt;
    logic            first_acc, last_acc, busy, layer_done, cfg_err;

    npu_df_seq #(
        .NT_W (NT_W),
        .MT_W (MT_W),
        .YT_W (YT_W)
    ) u_dut (
        .clk_trans   (clk_trans),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .Nt_times    (Nt_times),
        .Mt_times    (Mt_times),
        .IYt_times   (IYt_times),
        .ft_ifm_req  (ft_ifm_req),
        .ft_wt_req   (ft_wt_req),
        .cal_req     (cal_req),
        .tx_ofm_req  (tx_ofm_req),
        .ft_ifm_done (ft_ifm_done),
        .ft_wt_done  (ft_wt_done),
        .cal_done    (cal_done),
        .tx_ofm_done (tx_ofm_done),
        .n_cnt       (n_cnt),
        .m_cnt       (m_cnt),
        .y_cnt       (y_cnt),
        .first_acc   (first_acc),
        .last_acc    (last_acc),
        .busy        (busy),
        .layer_done  (layer_done),
        .cfg_err     (cfg_err)
    );

    always #5 clk_trans = ~clk_trans;

    // ------------------------------------------------------------------
    // Records
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]      kind;   // 0 ifm, 1 wt, 2 cal, 3 tx
        logic [NT_W-1:0] n;
        logic [MT_W-1:0] m;
        logic [YT_W-1:0] y;
        logic            first;
        logic            last;
    } ev_t;

    typedef struct {
        bit mode;
        int nt;
        int mt;
        int yt;
        int lat;
        bit spur;
        bit exp_err;
        int e_ifm;
        int e_wt;
        int e_cal;
        int e_tx;
        int e_cycles;   // start-to-layer_done latency, 0 = not checked
    } vec_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  c_ifm = 0, c_wt = 0, c_cal = 0, c_tx = 0;
    bit  mon_en   = 1'b0;
    bit  resp_en  = 1'b0;
    int  cur_lat  = 0;
    bit  cur_spur = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input int k, input int n, input int m, input int y,
                                 input bit f, input bit l);
        ev_t e;
        e.kind  = 2'(k);
        e.n     = NT_W'(n);
        e.m     = MT_W'(m);
        e.y     = YT_W'(y);
        e.first = f;
        e.last  = l;
        sb.push_back(e);
    endfunction

    // Independent loop-nest model of the request stream
    function automatic void build_expected(input vec_t v);
        sb.delete();
        if (v.mode == 1'b0) begin
            for (int n = 0; n < v.nt; n++)
                for (int y = 0; y < v.yt; y++) begin
                    for (int m = 0; m < v.mt; m++) begin
                        push(0, n, m, y, 1'b0, 1'b0);
                        push(1, n, m, y, 1'b0, 1'b0);
                        push(2, n, m, y, m == 0, m == v.mt - 1);
                    end
                    push(3, n, v.mt - 1, y, 1'b0, 1'b0);
                end
        end else begin
            for (int n = 0; n < v.nt; n++)
                for (int m = 0; m < v.mt; m++) begin
                    push(1, n, m, 0, 1'b0, 1'b0);
                    for (int y = 0; y < v.yt; y++) begin
                        push(0, n, m, y, 1'b0, 1'b0);
                        push(2, n, m, y, m == 0, m == v.mt - 1);
                        if (m == v.mt - 1) push(3, n, m, y, 1'b0, 1'b0);
                    end
                end
        end
    endfunction

    task automatic take_ev(input int k);
        ev_t act;
        ev_t exp;
        act = {2'(k), n_cnt, m_cnt, y_cnt, first_acc, last_acc};
        case (k)
            0: c_ifm++;
            1: c_wt++;
            2: c_cal++;
            default: c_tx++;
        endcase
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra_req: actual %0h required none", act);
        end else begin
            exp = sb.pop_front();
            chk("req_event", act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare each request rising edge against the scoreboard
    // ------------------------------------------------------------------
    initial begin
        logic p_ifm, p_wt, p_cal, p_tx;
        p_ifm = 1'b0; p_wt = 1'b0; p_cal = 1'b0; p_tx = 1'b0;
        forever begin
            @(negedge clk_trans);
            if (mon_en) begin
                chk("req_onehot",
                    $countones({ft_ifm_req, ft_wt_req, cal_req, tx_ofm_req, layer_done}) <= 1, 1);
                chk("acc_gate", (first_acc | last_acc) & ~cal_req, 0);
                if (ft_ifm_req && !p_ifm) take_ev(0);
                if (ft_wt_req  && !p_wt)  take_ev(1);
                if (cal_req    && !p_cal) take_ev(2);
                if (tx_ofm_req && !p_tx)  take_ev(3);
            end
            p_ifm = ft_ifm_req;
            p_wt  = ft_wt_req;
            p_cal = cal_req;
            p_tx  = tx_ofm_req;
        end
    end

    // ------------------------------------------------------------------
    // Responder: answers each request after cur_lat cycles
    // ------------------------------------------------------------------
    initial begin
        int waited;
        waited = 0;
        forever begin
            @(negedge clk_trans);
            if (resp_en) begin
                ft_ifm_done = 1'b0;
                ft_wt_done  = 1'b0;
                cal_done    = 1'b0;
                tx_ofm_done = 1'b0;
                if (ft_ifm_req | ft_wt_req | cal_req | tx_ofm_req) begin
                    if (waited >= cur_lat) begin
                        ft_ifm_done = ft_ifm_req;
                        ft_wt_done  = ft_wt_req;
                        cal_done    = cal_req;
                        tx_ofm_done = tx_ofm_req;
                        waited = 0;
                    end else begin
                        waited++;
                        if (cur_spur && ft_ifm_req) ft_wt_done = 1'b1;
                    end
                end else begin
                    waited = 0;
                end
            end
        end
    end

    task automatic run_layer(input vec_t v);
        int cyc;
        c_ifm = 0; c_wt = 0; c_cal = 0; c_tx = 0;
        if (v.exp_err) sb.delete();
        else build_expected(v);
        @(negedge clk_trans);
        mode      = v.mode;
        Nt_times  = NT_W'(v.nt);
        Mt_times  = MT_W'(v.mt);
        IYt_times = YT_W'(v.yt);
        cur_lat   = v.lat;
        cur_spur  = v.spur;
        start     = 1'b1;
        @(negedge clk_trans);
        start = 1'b0;
        cyc   = 1;
        if (v.exp_err) begin
            chk("cfg_err_pulse", cfg_err, 1);
            chk("cfg_err_busy", busy, 0);
            @(negedge clk_trans);
            chk("cfg_err_clear", {cfg_err, busy}, 0);
        end else begin
            chk("first_req", v.mode ? ft_wt_req : ft_ifm_req, 1);
            while (!layer_done && cyc < 5000) begin
                @(negedge clk_trans);
                cyc++;
                if (v.spur && cyc == 3) begin
                    start    = 1'b1;
                    mode     = ~v.mode;
                    Nt_times = NT_W'(7);
                end
                if (v.spur && cyc == 4) begin
                    start    = 1'b0;
                    mode     = v.mode;
                    Nt_times = NT_W'(v.nt);
                end
            end
            chk("layer_done_seen", layer_done, 1);
            if (v.e_cycles > 0) chk("done_latency", cyc, v.e_cycles);
            chk("busy_in_done", busy, 1);
            @(negedge clk_trans);
            chk("busy_after_done", {busy, layer_done}, 0);
        end
        chk("cnt_ifm", c_ifm, v.e_ifm);
        chk("cnt_wt", c_wt, v.e_wt);
        chk("cnt_cal", c_cal, v.e_cal);
        chk("cnt_tx", c_tx, v.e_tx);
        chk("sb_leftover", sb.size(), 0);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        vec_t tbl[8];
        int   cyc;
        //          mode  nt mt yt lat spur err  ifm wt cal tx cyc
        tbl[0] = '{1'b0, 1, 1, 1, 0, 1'b0, 1'b0,  1,  1,  1, 1, 5};
        tbl[1] = '{1'b0, 2, 3, 2, 0, 1'b0, 1'b0, 12, 12, 12, 4, 0};
        tbl[2] = '{1'b1, 2, 3, 2, 1, 1'b0, 1'b0, 12,  6, 12, 4, 0};
        tbl[3] = '{1'b0, 1, 0, 1, 0, 1'b0, 1'b1,  0,  0,  0, 0, 0};
        tbl[4] = '{1'b0, 2, 3, 2, 2, 1'b1, 1'b0, 12, 12, 12, 4, 0};
        tbl[5] = '{1'b1, 1, 1, 1, 0, 1'b0, 1'b0,  1,  1,  1, 1, 5};
        tbl[6] = '{1'b1, 3, 2, 1, 0, 1'b0, 1'b0,  6,  6,  6, 3, 0};
        tbl[7] = '{1'b1, 2, 3, 2, 1, 1'b1, 1'b0, 12,  6, 12, 4, 0};

        repeat (3) @(negedge clk_trans);
        chk("reset_state",
            {ft_ifm_req, ft_wt_req, cal_req, tx_ofm_req, n_cnt, m_cnt, y_cnt,
             first_acc, last_acc, busy, layer_done, cfg_err}, 0);
        rst     = 1'b0;
        mon_en  = 1'b1;
        resp_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_layer(tbl[i]);
        end

        // Reset in the middle of a CAL, followed by a stale cal_done
        mon_en = 1'b0;
        sb.delete();
        @(negedge clk_trans);
        mode      = 1'b0;
        Nt_times  = NT_W'(2);
        Mt_times  = MT_W'(3);
        IYt_times = YT_W'(2);
        cur_lat   = 1;
        cur_spur  = 1'b0;
        start     = 1'b1;
        @(negedge clk_trans);
        start = 1'b0;
        cyc   = 0;
        while (!(cal_req && m_cnt == MT_W'(1)) && cyc < 500) begin
            @(negedge clk_trans);
            cyc++;
        end
        chk("reached_cal", cal_req, 1);
        resp_en     = 1'b0;
        ft_ifm_done = 1'b0;
        ft_wt_done  = 1'b0;
        cal_done    = 1'b0;
        tx_ofm_done = 1'b0;
        rst         = 1'b1;
        @(negedge clk_trans);
        rst = 1'b0;
        chk("rst_abort",
            {ft_ifm_req, ft_wt_req, cal_req, tx_ofm_req, n_cnt, m_cnt, y_cnt,
             first_acc, last_acc, busy, layer_done, cfg_err}, 0);
        cal_done = 1'b1;
        @(negedge clk_trans);
        cal_done = 1'b0;
        chk("rst_late_done",
            {ft_ifm_req, ft_wt_req, cal_req, tx_ofm_req, n_cnt, m_cnt, y_cnt,
             first_acc, last_acc, busy, layer_done, cfg_err}, 0);
        @(negedge clk_trans);
        chk("rst_idle_hold", {busy, ft_ifm_req, ft_wt_req, cal_req, tx_ofm_req}, 0);

        // Recovery after abort
        mon_en  = 1'b1;
        resp_en = 1'b1;
        run_layer(tbl[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
